axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- AXI-Lite initiator that turns a simple valid/ready command stream into single AXI-Lite read or write transactions.
- Returns each completion, with its data and response code, on a valid/ready response stream.
- Drives register slaves such as the blinky register block, from a UART/debug bridge or a boot-time init sequencer.
- One transaction outstanding at a time.

Parameters:
- AXIL_ADDR_WIDTH, 8, AXI-Lite address width.
- AXIL_DATA_WIDTH, 32, AXI-Lite data width; strobe width is AXIL_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AXIL_ADDR_WIDTH  target address
- cmd_wdata  in  AXIL_DATA_WIDTH  write data
- cmd_wstrb  in  AXIL_DATA_WIDTH/8  write strobes
- rsp_valid  out  1  completion valid
- rsp_ready  in  1  completion consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  AXIL_DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  bresp or rresp, or the timeout code
- m_axil_aw*/w*/b*/ar*/r*  standard AXI-Lite master channels: awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All valids and readies low; cmd_ready=0 during reset.
  - Address, data and response registers zero; state IDLE.
  - Any in-flight transaction is abandoned; no rsp is produced for it.
- States: IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register addr/data/wstrb/write.
  - Write command: next cycle awvalid=1 and wvalid=1; go WRITE.
  - Read command: next cycle arvalid=1; go RD_ADDR.
  - All AXI outputs are registered.
- WRITE:
  - awvalid and wvalid drop independently in the cycle after their own handshake; aw and w may complete in either order or together.
  - When both have completed, bready=1; go WR_RESP.
  - AXI payload (awaddr, wdata, wstrb) stays stable while its valid is high.
- WR_RESP:
  - On bvalid&&bready: bready<=0; capture bresp; rsp_rdata=0; go RSP.
- RD_ADDR:
  - On arready: arvalid<=0; rready<=1; go RD_DATA.
- RD_DATA:
  - On rvalid&&rready: rready<=0; capture rdata and rresp; go RSP.
- RSP:
  - rsp_valid=1; payload stable until rsp_ready.
  - On the handshake, rsp_valid<=0; go IDLE.
  - cmd_ready stays 0 until back in IDLE, so a new command is accepted no earlier than the cycle after the rsp handshake.
- Minimum latency, cmd handshake to rsp_valid:
  - Write: 3 cycles with a zero-wait slave (aw/w, then b, then rsp).
  - Read: 3 cycles with a zero-wait slave (ar, then r, then rsp).
- No address decode or range checking: slave responses (including 2'b11 DECERR) pass through unchanged.
- Protocol rules:
  - Valids never deassert before their handshake.
  - No combinational path from any input to any output.

Optional Feature:
- Macro: AXIL_CMD_MASTER_TIMEOUT_EN.
- When defined:
  - A counter runs in WRITE, WR_RESP, RD_ADDR and RD_DATA, cleared on each state entry.
  - On reaching TIMEOUT_CYCLES, all AXI valids and readies drop.
  - Completion is rsp_resp=2'b10 (SLVERR) and rsp_rdata=0; go RSP.
  - Late slave responses are not tracked; the integration owner guarantees the slave has been reset or is idle before reuse.
- When undefined: no counter logic; the block waits indefinitely.

Decomposition:
- Package axil_pkg holds:
  - State enum.
  - Response constants AXIL_RESP_OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- No sub-module; single FSM file.

Test Plan:
- Bench slave is the blinky register block at CLK_FREQ=100_000_000.
- Reset: after rst, all AXI valids=0, rsp_valid=0; first post-reset cycle cmd_ready=1.
- Read 0x01 -> rsp_write=0, rsp_rdata=1, rsp_resp=0. Read 0x02 -> rsp_rdata=100_000_000.
- Write 0x00=32'h1, wstrb=4'hF -> rsp_resp=0, rsp_rdata=0; then read 0x00 -> 1; led high within 10 cycles.
- Write 0x04 -> rsp_resp=2'b11, passed through unchanged.
- Stub slave with awready at cycle +1 and wready at cycle +4:
  - awvalid drops first while wvalid stays high.
  - Exactly one b handshake occurs.
- Stub slave with rsp_ready held low for 5 cycles: rsp payload stable, cmd_ready=0 throughout, next command accepted only after the handshake.
- rst pulsed during RD_DATA: next cycle all outputs at reset values and no rsp is emitted.
- With AXIL_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, stub slave that never asserts arready -> rsp_resp=2'b10 after 16 cycles.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite command master: FSM state encoding
// and the AXI-Lite response codes.
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } axil_state_e;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_master.sv
// AXI-Lite initiator: converts a valid/ready command stream into single
// AXI-Lite read or write transactions (one outstanding) and returns each
// completion on a valid/ready response stream. Every output is a flop.
//
// Optional feature: define AXIL_CMD_MASTER_TIMEOUT_EN to add a watchdog that
// abandons a transaction after TIMEOUT_CYCLES cycles in a single wait state
// and completes it with SLVERR. Without the macro the block waits forever.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    // command stream
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb,
    // response stream
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_write,
    output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                   rsp_resp,
    // AXI-Lite master
    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                         m_axil_awvalid,
    input  logic                         m_axil_awready,
    output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                         m_axil_wvalid,
    input  logic                         m_axil_wready,
    input  logic [1:0]                   m_axil_bresp,
    input  logic                         m_axil_bvalid,
    output logic                         m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                         m_axil_arvalid,
    input  logic                         m_axil_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]                   m_axil_rresp,
    input  logic                         m_axil_rvalid,
    output logic                         m_axil_rready
);

    localparam int STRB_W = AXIL_DATA_WIDTH / 8;

    // A zero watchdog limit would fire before any slave could answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 1");
    end

    axil_state_e                state_r;
    logic                       cmd_ready_r;
    logic [AXIL_ADDR_WIDTH-1:0] awaddr_r;
    logic                       awvalid_r;
    logic [AXIL_DATA_WIDTH-1:0] wdata_r;
    logic [STRB_W-1:0]          wstrb_r;
    logic                       wvalid_r;
    logic                       bready_r;
    logic [AXIL_ADDR_WIDTH-1:0] araddr_r;
    logic                       arvalid_r;
    logic                       rready_r;
    logic                       rsp_valid_r;
    logic                       rsp_write_r;
    logic [AXIL_DATA_WIDTH-1:0] rsp_rdata_r;
    logic [1:0]                 rsp_resp_r;

    // A channel is finished once its valid is already low or is being accepted now.
    logic aw_done_s;
    logic w_done_s;
    assign aw_done_s = !awvalid_r || m_axil_awready;
    assign w_done_s  = !wvalid_r  || m_axil_wready;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    axil_state_e      last_state_r;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] count_s;
    logic             busy_s;
    logic             timeout_s;

    // Cycles spent in the current wait state, counting the present one; restarts at 1 on entry.
    always_comb begin
        busy_s    = 1'b0;
        count_s   = TMR_W'(1);
        timeout_s = 1'b0;
        case (state_r)
            ST_WRITE, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA: busy_s = 1'b1;
            default:                                      busy_s = 1'b0;
        endcase
        if (state_r == last_state_r) begin
            count_s = timer_r + TMR_W'(1);
        end else begin
            count_s = TMR_W'(1);
        end
        timeout_s = busy_s && (count_s == TMR_W'(TIMEOUT_CYCLES));
    end

    // Watchdog counter, tracking the previous state to detect state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_state_r <= ST_IDLE;
            timer_r      <= '0;
        end else begin
            last_state_r <= state_r;
            if (busy_s) begin
                timer_r <= count_s;
            end else begin
                timer_r <= '0;
            end
        end
    end
`endif

    // Transaction FSM; all AXI and stream outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            awaddr_r    <= '0;
            awvalid_r   <= 1'b0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            araddr_r    <= '0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_resp_r  <= AXIL_RESP_OKAY;
        end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        // The watchdog wins over a coincident slave handshake; late responses are not tracked.
        else if (timeout_s) begin
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_resp_r  <= AXIL_RESP_SLVERR;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RSP;
        end
`endif
        else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        cmd_ready_r <= 1'b0;
                        rsp_write_r <= cmd_write;
                        if (cmd_write) begin
                            awaddr_r  <= cmd_addr;
                            wdata_r   <= cmd_wdata;
                            wstrb_r   <= cmd_wstrb;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= ST_WRITE;
                        end else begin
                            araddr_r  <= cmd_addr;
                            arvalid_r <= 1'b1;
                            state_r   <= ST_RD_ADDR;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (awvalid_r && m_axil_awready) begin
                        awvalid_r <= 1'b0;
                    end
                    if (wvalid_r && m_axil_wready) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready_r <= 1'b1;
                        state_r  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axil_bvalid && bready_r) begin
                        bready_r    <= 1'b0;
                        rsp_resp_r  <= m_axil_bresp;
                        rsp_rdata_r <= '0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RSP;
                    end
                end
                ST_RD_ADDR: begin
                    if (arvalid_r && m_axil_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axil_rvalid && rready_r) begin
                        rready_r    <= 1'b0;
                        rsp_rdata_r <= m_axil_rdata;
                        rsp_resp_r  <= m_axil_rresp;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    // cmd_ready rises together with the return to IDLE.
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    bready_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    cmd_ready_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_write      = rsp_write_r;
    assign rsp_rdata      = rsp_rdata_r;
    assign rsp_resp       = rsp_resp_r;
    assign m_axil_awaddr  = awaddr_r;
    assign m_axil_awvalid = awvalid_r;
    assign m_axil_wdata   = wdata_r;
    assign m_axil_wstrb   = wstrb_r;
    assign m_axil_wvalid  = wvalid_r;
    assign m_axil_bready  = bready_r;
    assign m_axil_araddr  = araddr_r;
    assign m_axil_arvalid = arvalid_r;
    assign m_axil_rready  = rready_r;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master. The slave is a behavioural model of the
// blinky register block (0x00 control/LED, 0x01 = 1, 0x02 = CLK_FREQ, other
// addresses DECERR) with adjustable ready latencies and stall switches.
module tb_axil_cmd_master;
    import axil_pkg::*;

    localparam int AW       = 8;
    localparam int DW       = 32;
    localparam int SW       = DW / 8;
    localparam int CLK_FREQ = 100_000_000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [AW-1:0] araddr;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid, rready;

    always #5 clk = ~clk;

    axil_cmd_master #(
        .AXIL_ADDR_WIDTH(AW),
        .AXIL_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
        .m_axil_wready(wready), .m_axil_bresp(bresp), .m_axil_bvalid(bvalid),
        .m_axil_bready(bready), .m_axil_araddr(araddr), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    // ---------------- behavioural slave ----------------
    int            aw_lat = 0;
    int            w_lat  = 0;
    logic          ar_block = 1'b0;
    logic          r_block  = 1'b0;
    int            aw_wait, w_wait;
    logic          aw_have, w_have;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic [DW-1:0] ctrl_reg;
    logic          led;
    logic          aw_hs, w_hs, wr_go;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign led = ctrl_reg[0];

    // Slave ready generation and write-merge decode.
    always_comb begin
        awready = awvalid && !aw_have && (aw_wait >= aw_lat);
        wready  = wvalid && !w_have && (w_wait >= w_lat);
        arready = arvalid && !ar_block && !rvalid;
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        wr_addr = aw_hs ? awaddr : aw_addr_q;
        wr_data = w_hs ? wdata : w_data_q;
        wr_strb = w_hs ? wstrb : w_strb_q;
        wr_go   = (aw_have || aw_hs) && (w_have || w_hs) && !bvalid;
    end

    // Slave register file and response channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; aw_have <= 1'b0; w_have <= 1'b0;
            aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0; ctrl_reg <= '0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            if (aw_hs) begin aw_have <= 1'b1; aw_addr_q <= awaddr; end
            if (w_hs) begin w_have <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; end
            if (wr_go) begin
                aw_have <= 1'b0;
                w_have  <= 1'b0;
                bvalid  <= 1'b1;
                if (wr_addr == 8'h00) begin
                    ctrl_reg <= merge(ctrl_reg, wr_data, wr_strb);
                    bresp    <= AXIL_RESP_OKAY;
                end else begin
                    bresp <= AXIL_RESP_DECERR;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arready && !r_block) begin
                rvalid <= 1'b1;
                case (araddr)
                    8'h00:   begin rdata <= ctrl_reg;         rresp <= AXIL_RESP_OKAY;   end
                    8'h01:   begin rdata <= 32'd1;            rresp <= AXIL_RESP_OKAY;   end
                    8'h02:   begin rdata <= 32'(CLK_FREQ);    rresp <= AXIL_RESP_OKAY;   end
                    default: begin rdata <= 32'd0;            rresp <= AXIL_RESP_DECERR; end
                endcase
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- protocol monitor ----------------
    int            b_hs_cnt = 0, split_cnt = 0, rsplit_cnt = 0, stab_err = 0;
    logic          aw_pend_q = 1'b0, w_pend_q = 1'b0, ar_pend_q = 1'b0;
    logic [AW-1:0] aw_prev = '0, ar_prev = '0;
    logic [DW-1:0] w_prev = '0;
    logic [SW-1:0] ws_prev = '0;

    // Count b handshakes, aw/w split cycles and valid/payload stability violations.
    always_ff @(posedge clk) begin
        if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
        if (!awvalid && wvalid) split_cnt <= split_cnt + 1;
        if (awvalid && !wvalid) rsplit_cnt <= rsplit_cnt + 1;
        aw_pend_q <= !rst && awvalid && !awready;
        w_pend_q  <= !rst && wvalid && !wready;
        ar_pend_q <= !rst && arvalid && !arready;
        aw_prev <= awaddr; w_prev <= wdata; ws_prev <= wstrb; ar_prev <= araddr;
        if ((aw_pend_q && (!awvalid || awaddr != aw_prev)) ||
            (w_pend_q && (!wvalid || wdata != w_prev || wstrb != ws_prev)) ||
            (ar_pend_q && (!arvalid || araddr != ar_prev)))
            stab_err <= stab_err + 1;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept: cmd_ready still 0 after %0d cycles", n);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic w, output logic [DW-1:0] d,
                           output logic [1:0] r, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 100);
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_wait: rsp_valid still 0 after %0d cycles", lat);
        end
        w = rsp_write; d = rsp_rdata; r = rsp_resp;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_resp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic          gw;
        logic [DW-1:0] gd;
        logic [1:0]    gr;
        int            lat, b0, s0, r0, n, seen;

        vecs[0] = '{1'b0, 8'h01, 32'h0,         4'h0, 32'h0000_0001, 2'b00};
        vecs[1] = '{1'b0, 8'h02, 32'h0,         4'h0, 32'd100_000_000, 2'b00};
        vecs[2] = '{1'b1, 8'h00, 32'h0000_0001, 4'hF, 32'h0,         2'b00};
        vecs[3] = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h0000_0001, 2'b00};
        vecs[4] = '{1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b11};
        vecs[5] = '{1'b0, 8'h07, 32'h0,         4'h0, 32'h0,         2'b11};
        vecs[6] = '{1'b1, 8'h00, 32'hA5A5_A5A4, 4'h1, 32'h0,         2'b00};
        vecs[7] = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h0000_00A4, 2'b00};
        vecs[8] = '{1'b1, 8'h00, 32'h1234_5601, 4'h6, 32'h0,         2'b00};
        vecs[9] = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h0034_56A4, 2'b00};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        check("reset_readies", {29'd0, bready, rready, cmd_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_payload", rsp_rdata | {30'd0, rsp_resp}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Table-driven transactions against a zero-wait slave
        for (int i = 0; i < 10; i++) begin
            send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            get_rsp(gw, gd, gr, lat);
            check($sformatf("v%0d_write", i), {31'd0, gw}, {31'd0, vecs[i].wr});
            check($sformatf("v%0d_rdata", i), gd, vecs[i].exp_rdata);
            check($sformatf("v%0d_resp", i), {30'd0, gr}, {30'd0, vecs[i].exp_resp});
            check($sformatf("v%0d_latency", i), lat, 32'd3);
        end

        // LED follows control bit 0 within 10 cycles of the write command
        check("led_low_before", {31'd0, led}, 32'd0);
        send_cmd(1'b1, 8'h00, 32'h0000_0001, 4'hF);
        n = 0;
        while (!led && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("led_high", {31'd0, led}, 32'd1);
        get_rsp(gw, gd, gr, lat);
        check("led_write_resp", {30'd0, gr}, 32'd0);

        // aw accepted after 1 cycle, w after 4: aw drops first, one b handshake
        aw_lat = 1; w_lat = 4;
        b0 = b_hs_cnt; s0 = split_cnt; r0 = rsplit_cnt;
        send_cmd(1'b1, 8'h00, 32'h0000_0003, 4'hF);
        get_rsp(gw, gd, gr, lat);
        aw_lat = 0; w_lat = 0;
        check("split_aw_first", {31'd0, (split_cnt - s0) >= 2}, 32'd1);
        check("split_no_w_first", rsplit_cnt - r0, 32'd0);
        check("split_one_b", b_hs_cnt - b0, 32'd1);
        check("split_resp", {30'd0, gr}, 32'd0);
        check("split_rdata", gd, 32'd0);
        send_cmd(1'b0, 8'h00, 32'h0, 4'h0);
        get_rsp(gw, gd, gr, lat);
        check("split_readback", gd, 32'h0000_0003);

        // rsp_ready held low for 5 cycles with a second command waiting
        send_cmd(1'b0, 8'h02, 32'h0, 4'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h01;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_payload", k),
                  {28'd0, rsp_valid, rsp_write, rsp_resp} ^ rsp_rdata, 32'h8 ^ 32'd100_000_000);
            check($sformatf("hold%0d_cmd_ready", k), {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("after_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("after_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("after_hs_not_yet_accepted", {31'd0, arvalid}, 32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("next_cmd_arvalid", {31'd0, arvalid}, 32'd1);
        get_rsp(gw, gd, gr, lat);
        check("next_cmd_rdata", gd, 32'd1);

        // Valids/payloads never changed before their handshakes
        check("stability_violations", stab_err, 32'd0);

        // Reset pulsed while waiting in RD_DATA: transaction abandoned, no rsp
        r_block = 1'b1;
        send_cmd(1'b0, 8'h01, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("rd_data_rready", {31'd0, rready}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_outputs",
              {25'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 32'd0);
        check("midrst_payload", rsp_rdata | {30'd0, rsp_resp}, 32'd0);
        rst = 1'b0;
        r_block = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("midrst_no_rsp", seen, 32'd0);
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        send_cmd(1'b0, 8'h02, 32'h0, 4'h0);
        get_rsp(gw, gd, gr, lat);
        check("midrst_recover_rdata", gd, 32'd100_000_000);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        // Slave never asserts arready: SLVERR after 16 cycles in RD_ADDR
        ar_block = 1'b1;
        send_cmd(1'b0, 8'h02, 32'h0, 4'h0);
        get_rsp(gw, gd, gr, lat);
        check("timeout_resp", {30'd0, gr}, {30'd0, AXIL_RESP_SLVERR});
        check("timeout_rdata", gd, 32'd0);
        check("timeout_latency", lat, 32'd17);
        check("timeout_arvalid_dropped", {31'd0, arvalid}, 32'd0);
        ar_block = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
